// File: rtl/data_mem_responder.sv
// Load/store responder for the RV32I data port: byte-lane word RAM with
// sub-word access, sign/zero extension and split handling of word-crossing accesses.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_WE,
  input  logic [2:0]  mem_MODE,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        rsp_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FIRST  = 3'd1,
    S_SECOND = 3'd2,
    S_RESP   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  localparam logic [30:0] DEPTH_L = 31'(DEPTH_WORDS);

  state_t state_reg, state_next;
  logic   ready_en_reg;
  logic   accept;

  logic [1:0]  req_size;
  logic [2:0]  req_n;
  logic [3:0]  req_end;
  logic        req_cross;
  logic        req_fault;
  logic [30:0] req_word;
  logic [7:0]  req_be;
  logic [63:0] req_shift;

  logic [IDX_W-1:0] a0_reg;
  logic [1:0]       off_reg;
  logic [2:0]       mode_reg;
  logic             we_reg;
  logic             cross_reg;
  logic [7:0]       be_reg;
  logic [63:0]      shift_reg;

  logic [IDX_W-1:0] ram_addr;
  logic [31:0]      rd_q;
  logic [31:0]      buf0_reg;
  logic [31:0]      load_lo;
  logic [31:0]      load_raw;
  logic [31:0]      load_data;
  logic [31:0]      rdata_reg;

  // Request decode: byte-enable mask and shifted store data span two words (8 lanes).
  always_comb begin
    req_size = mem_MODE[1:0];
    case (req_size)
      2'b01:   req_n = 3'd2;
      2'b10:   req_n = 3'd1;
      default: req_n = 3'd4;
    endcase
    req_end   = {2'b00, addr[1:0]} + {1'b0, req_n};
    req_cross = (req_end > 4'd4);
    req_word  = {1'b0, addr[31:2]};
    req_fault = (req_size == 2'b11) || (req_word >= DEPTH_L) ||
                (req_cross && ((req_word + 31'd1) >= DEPTH_L));
    req_be    = ((8'd1 << req_n) - 8'd1) << addr[1:0];
    req_shift = {32'd0, wdata} << {addr[1:0], 3'b000};
  end

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      ready_en_reg <= 1'b0;
      rdata_reg    <= 32'd0;
    end else begin
      state_reg    <= state_next;
      ready_en_reg <= 1'b1;
      if (state_reg == S_RESP && !we_reg) begin
        rdata_reg <= load_data;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (accept) state_next = req_fault ? S_ERR : S_FIRST;
      S_FIRST:  state_next = cross_reg ? S_SECOND : S_RESP;
      S_SECOND: state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
      S_ERR:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = ready_en_reg && (state_reg == S_IDLE);
    rsp_valid = (state_reg == S_RESP) || (state_reg == S_ERR);
    rsp_err   = (state_reg == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a0_reg    <= req_word[IDX_W-1:0];
      off_reg   <= addr[1:0];
      mode_reg  <= mem_MODE;
      we_reg    <= mem_WE;
      cross_reg <= req_cross;
      be_reg    <= req_be;
      shift_reg <= req_shift;
    end
    if (state_reg == S_SECOND) begin
      buf0_reg <= rd_q;
    end
  end

  assign ram_addr = (state_reg == S_SECOND) ? (a0_reg + IDX_W'(1)) : a0_reg;

  // One RAM per byte lane so partial stores leave neighbouring lanes untouched.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      logic [7:0] lane_q;
      logic       lane_we;
      logic [7:0] lane_wbyte;

      assign lane_we = we_reg &&
                       (((state_reg == S_FIRST) && be_reg[gi]) ||
                        ((state_reg == S_SECOND) && be_reg[gi+4]));
      assign lane_wbyte = (state_reg == S_SECOND) ? shift_reg[32+8*gi +: 8]
                                                  : shift_reg[8*gi +: 8];

      always_ff @(posedge clk) begin
        if (lane_we) begin
          lane_mem[ram_addr] <= lane_wbyte;
        end
        lane_q <= lane_mem[ram_addr];
      end

      assign rd_q[8*gi +: 8] = lane_q;
    end
  endgenerate

  // In RESP the read register holds the last word fetched; the first word of a split is in buf0.
  always_comb begin
    load_lo  = cross_reg ? buf0_reg : rd_q;
    load_raw = 32'({rd_q, load_lo} >> {off_reg, 3'b000});
    case (mode_reg[1:0])
      2'b01:   load_data = {{16{mode_reg[2] & load_raw[15]}}, load_raw[15:0]};
      2'b10:   load_data = {{24{mode_reg[2] & load_raw[7]}}, load_raw[7:0]};
      default: load_data = load_raw;
    endcase
  end

  assign rdata = ((state_reg == S_RESP) && !we_reg) ? load_data : rdata_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed steps plus random traffic checked
// against a byte-addressed reference memory.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int IDXW  = 10;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] addr      = 32'd0;
  logic [31:0] wdata     = 32'd0;
  logic        mem_WE    = 1'b0;
  logic [2:0]  mem_MODE  = 3'd0;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref_mem [4*DEPTH];
  logic [31:0] hold_rdata = 32'd0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .IDX_W(IDXW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .addr      (addr),
    .wdata     (wdata),
    .mem_WE    (mem_WE),
    .mem_MODE  (mem_MODE),
    .rsp_valid (rsp_valid),
    .rdata     (rdata),
    .rsp_err   (rsp_err)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One request/response; expectations come from the byte-level model.
  task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic we,
                     input logic [2:0] md, output logic [31:0] got);
    int          n;
    bit          fault;
    int          exp_lat;
    logic [31:0] exp_rd;
    int          lat;
    bit          seen;
    int          waits;

    case (md[1:0])
      2'b00:   n = 4;
      2'b01:   n = 2;
      2'b10:   n = 1;
      default: n = 0;
    endcase
    fault   = (md[1:0] == 2'b11) || ((longint'(a) + longint'(n)) > longint'(4*DEPTH));
    exp_lat = fault ? 1 : ((int'(a[1:0]) + n > 4) ? 3 : 2);
    if (!fault && !we) begin
      exp_rd = 32'd0;
      for (int i = 0; i < n; i++) exp_rd[8*i +: 8] = ref_mem[int'(a) + i];
      if (md[2] && exp_rd[8*n-1]) begin
        for (int i = n; i < 4; i++) exp_rd[8*i +: 8] = 8'hFF;
      end
      hold_rdata = exp_rd;
    end else begin
      exp_rd = hold_rdata;
    end
    if (!fault && we) begin
      for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
    end

    waits = 0;
    while (req_ready !== 1'b1 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    check32("req_ready_before_request", {31'd0, req_ready}, 32'd1);

    req_valid = 1'b1;
    addr      = a;
    wdata     = wd;
    mem_WE    = we;
    mem_MODE  = md;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    addr      = $urandom;
    wdata     = $urandom;
    mem_WE    = 1'($urandom);
    mem_MODE  = 3'($urandom);

    lat  = 1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        seen = 1;
        break;
      end
      lat++;
    end
    check_int("latency", seen ? lat : -1, exp_lat);
    check32("rsp_err", {31'd0, rsp_err}, {31'd0, fault});
    check32("rdata", rdata, exp_rd);
    check32("ready_during_rsp", {31'd0, req_ready}, 32'd0);
    got = rdata;
    $display("txn addr=%h wdata=%h we=%0d mode=%b lat=%0d err=%0d rdata=%h",
             a, wd, we, md, lat, rsp_err, rdata);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] ra;
    logic [2:0]  rm;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("reset_req_ready", {31'd0, req_ready}, 32'd0);
    check32("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check32("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    check32("reset_rdata", rdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check32("ready_after_release", {31'd0, req_ready}, 32'd1);

    // Initialise the regions used below so every load has known contents
    for (int w = 0; w <= 64; w++) txn(32'(4*w), $urandom, 1'b1, 3'b000, got);
    for (int w = DEPTH-2; w < DEPTH; w++) txn(32'(4*w), $urandom, 1'b1, 3'b000, got);

    // Word store/load
    txn(32'h10, 32'hDEADBEEF, 1'b1, 3'b000, got);
    txn(32'h10, 32'h0, 1'b0, 3'b000, got);
    check32("lw_0x10", got, 32'hDEADBEEF);

    // Sub-word loads with extension
    txn(32'h13, 32'h0, 1'b0, 3'b110, got);
    check32("lb_0x13", got, 32'hFFFFFFDE);
    txn(32'h13, 32'h0, 1'b0, 3'b010, got);
    check32("lbu_0x13", got, 32'h000000DE);
    txn(32'h12, 32'h0, 1'b0, 3'b101, got);
    check32("lh_0x12", got, 32'hFFFFDEAD);
    txn(32'h10, 32'h0, 1'b0, 3'b001, got);
    check32("lhu_0x10", got, 32'h0000BEEF);

    // Crossing store and load
    txn(32'h21, 32'h11223344, 1'b1, 3'b000, got);
    txn(32'h20, 32'h0, 1'b0, 3'b000, got);
    check32("cross_word20_lanes123", {8'd0, got[31:8]}, 32'h00223344);
    txn(32'h24, 32'h0, 1'b0, 3'b000, got);
    check32("cross_word24_lane0", {24'd0, got[7:0]}, 32'h00000011);
    txn(32'h21, 32'h0, 1'b0, 3'b000, got);
    check32("lw_cross_0x21", got, 32'h11223344);

    // Byte store keeps neighbours
    txn(32'h30, 32'hAABBCCDD, 1'b1, 3'b000, got);
    txn(32'h31, 32'h000000EE, 1'b1, 3'b010, got);
    txn(32'h30, 32'h0, 1'b0, 3'b000, got);
    check32("sb_preserve_0x30", got, 32'hAABBEEDD);

    // Faults: reserved size, out of range, crossing past the top
    txn(32'h40, 32'h0, 1'b0, 3'b011, got);
    txn(32'h40, 32'hCAFEF00D, 1'b1, 3'b011, got);
    txn(32'h40, 32'h0, 1'b0, 3'b000, got);
    txn(32'(4*DEPTH), 32'h0, 1'b0, 3'b000, got);
    txn(32'(4*DEPTH-2), 32'h0, 1'b0, 3'b000, got);
    txn(32'(4*DEPTH-2), 32'h12345678, 1'b1, 3'b000, got);
    txn(32'(4*DEPTH-4), 32'h0, 1'b0, 3'b000, got);
    txn(32'(4*DEPTH-2), 32'h0, 1'b0, 3'b001, got);

    // Random traffic
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 9) < 8) ra = 32'($urandom_range(0, 255));
      else ra = 32'(4*DEPTH - 8 + int'($urandom_range(0, 11)));
      rm = 3'($urandom_range(0, 7));
      txn(ra, $urandom, 1'($urandom), rm, got);
    end

    // Reset during the second half of a crossing store
    while (req_ready !== 1'b1) @(negedge clk);
    req_valid = 1'b1;
    addr      = 32'h21;
    wdata     = 32'h55667788;
    mem_WE    = 1'b1;
    mem_MODE  = 3'b000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ref_mem[32'h21] = 8'h88;
    ref_mem[32'h22] = 8'h77;
    ref_mem[32'h23] = 8'h66;
    hold_rdata = 32'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check32("midreset_req_ready", {31'd0, req_ready}, 32'd0);
      check32("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    end
    check32("midreset_rdata", rdata, 32'd0);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check32("post_reset_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    txn(32'h20, 32'h0, 1'b0, 3'b000, got);
    check32("midreset_word20_lanes123", {8'd0, got[31:8]}, 32'h00667788);
    txn(32'h24, 32'h0, 1'b0, 3'b000, got);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
